// File: rtl/tick_scheduler_pkg.sv
// Shared constants and FSM encoding for the tick scheduler and its channels.
package tick_scheduler_pkg;

   localparam int DEF_PRESCALE = 100;
   localparam int DEF_NUM_CH   = 4;
   localparam int DEF_PER_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

endpackage

// File: rtl/tick_scheduler_channel.sv
// One tick channel: period register, wrap counter in base ticks, apply-on-wrap
// logic for a pending period, and the registered tick pulse.
module tick_channel
   import tick_scheduler_pkg::*;
#(
   parameter int PER_W = DEF_PER_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             base_tick_i,
   input  logic             clear_i,
   input  logic             apply_i,
   input  logic             apply_now_i,
   input  logic [PER_W-1:0] period_i,
   output logic             tick_o,
   output logic             applied_o
);

   logic [PER_W-1:0] period_q, period_d;
   logic [PER_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             enabled;
   logic             wrap;

   assign enabled = (period_q != '0);
   assign wrap    = base_tick_i && enabled && (cnt_q == period_q - PER_W'(1));

   always_comb begin
      period_d  = period_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      applied_o = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (base_tick_i && enabled) begin
         cnt_d  = wrap ? '0 : cnt_q + PER_W'(1);
         tick_d = wrap;
      end
      // A running, enabled channel only swaps periods at a wrap so no interval is cut short.
      if (apply_i) begin
         if (apply_now_i || !enabled) begin
            period_d  = period_i;
            cnt_d     = '0;
            applied_o = 1'b1;
         end else if (wrap) begin
            period_d  = period_i;
            applied_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         period_q <= '0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: FSM, base-tick prescaler and a single pending
// configuration slot feeding NUM_CH tick_channel instances.
module tick_scheduler
   import tick_scheduler_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int PER_W    = DEF_PER_W,
   parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_i,
   input  logic              stop_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [PER_W-1:0]  cfg_period_i,
   output logic [NUM_CH-1:0] tick_o,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   localparam int PS_W = $clog2(PRESCALE);

   state_e state_q, state_d;
   logic   counting;
   logic   base_tick;
   logic   apply_now;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!stop_i && run_i) state_d = ST_RUN;
         ST_RUN:   if (stop_i) state_d = ST_IDLE;
                   else if (!run_i) state_d = ST_PAUSE;
         ST_PAUSE: if (stop_i) state_d = ST_IDLE;
                   else if (run_i) state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o    = (state_q == ST_RUN);
      counting  = (state_q == ST_RUN);
      apply_now = (state_q != ST_RUN) || stop_i;
      state_o   = state_q;
   end

   logic [PS_W-1:0] presc_q, presc_d;

   assign base_tick = counting && !stop_i && (presc_q == PS_W'(PRESCALE - 1));

   always_comb begin
      presc_d = presc_q;
      if (stop_i)        presc_d = '0;
      else if (counting) presc_d = base_tick ? '0 : presc_q + PS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) presc_q <= '0;
      else       presc_q <= presc_d;
   end

   // Handshake: a request transfers on any cycle with cfg_valid_i && cfg_ready_o;
   // cfg_ready_o is low exactly while the pending slot holds an unapplied request.
   logic              pend_valid_q, pend_valid_d;
   logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
   logic [PER_W-1:0]  pend_per_q, pend_per_d;
   logic [NUM_CH-1:0] apply_sel;
   logic [NUM_CH-1:0] applied;
   logic              in_range;

   assign cfg_ready_o = !pend_valid_q;
   assign in_range    = (32'(cfg_ch_i) < NUM_CH);

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_ch_d    = pend_ch_q;
      pend_per_d   = pend_per_q;
      if (pend_valid_q && (|applied)) pend_valid_d = 1'b0;
      if (cfg_valid_i && cfg_ready_o && in_range) begin
         pend_valid_d = 1'b1;
         pend_ch_d    = cfg_ch_i;
         pend_per_d   = cfg_period_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_ch_q    <= '0;
         pend_per_q   <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_ch_q    <= pend_ch_d;
         pend_per_q   <= pend_per_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign apply_sel[c] = pend_valid_q && (pend_ch_q == CH_W'(c));

      tick_channel #(
         .PER_W (PER_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .base_tick_i (base_tick),
         .clear_i     (stop_i),
         .apply_i     (apply_sel[c]),
         .apply_now_i (apply_now),
         .period_i    (pend_per_q),
         .tick_o      (tick_o[c]),
         .applied_o   (applied[c])
      );
   end

endmodule
